// File: rtl/axi_lite_arb_pkg.sv
// Shared types and helpers for the AXI-Lite command arbiter family.
//   arb_state_t : arbiter FSM encoding (IDLE, ISSUE, WAIT, RESP)
//   RESP_*      : AXI response codes used by requesters and benches
//   rr_next     : round-robin search, first set request above 'last', wrapping
package axi_lite_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Widest arbiter supported by rr_next; narrower request vectors are
  // zero-extended by the caller.
  localparam int unsigned MAX_REQ = 16;

  // Returns the first index with req set, searching upward from last+1 and
  // wrapping modulo n. Scanning from the farthest distance down to the
  // nearest lets the nearest candidate overwrite the others. Returns 'last'
  // when nothing is requesting.
  function automatic logic [3:0] rr_next(input logic [MAX_REQ-1:0] req,
                                         input logic [3:0]         last,
                                         input int unsigned        n);
    logic [3:0]  pick;
    int unsigned idx;
    pick = last;
    for (int unsigned k = MAX_REQ; k >= 1; k--) begin
      if (k <= n) begin
        idx = (32'(last) + k) % n;
        if (req[idx[3:0]]) pick = idx[3:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/axi_lite_cmd_arbiter_pick.sv
// rr_priority_pick: purely combinational round-robin selector.
//   req        : request vector, one bit per requester
//   last_grant : index granted most recently (search starts just above it)
//   grant      : selected index (equals last_grant when nothing requests)
//   any        : at least one request is set
module rr_priority_pick
  import axi_lite_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] last_grant,
  output logic [$clog2(N_REQ)-1:0] grant,
  output logic                     any
);

  localparam int IW = $clog2(N_REQ);

  assign any   = |req;
  assign grant = IW'(rr_next(MAX_REQ'(req), 4'(last_grant), N_REQ));

endmodule

// File: rtl/axi_lite_cmd_arbiter.sv
// axi_lite_cmd_arbiter: shares one AXI-Lite controller command port between
// N_REQ requesters, one transaction outstanding at a time, round-robin.
//
// Ports
//   axi_clk, sys_areset            : clock, async active-high reset
//   req_valid/write/addr/wdata/... : packed per-requester command inputs
//   rsp_valid (one-hot), rsp_resp, rsp_rdata : completion back to owner
//   busy, grant_id                 : status (state != IDLE, current/last owner)
//   ctrl_start_write/read          : one-cycle start pulses to the controller
//   ctrl_address/write_data/prot/be: registered command, stable until next grant
//   ctrl_resp/read_data/read_data_valid/done_write : controller completion
//   state_dbg                      : FSM state for observation
//
// Handshake: a requester raises req_valid with its fields and holds both
// until the cycle its rsp_valid bit pulses; it may drop or change them only on
// the edge ending that cycle. Once granted, later changes to req_* are
// ignored and the response is always delivered. Toward the controller, a
// start pulse launches the latched command; exactly one matching completion
// strobe (done_write for writes, read_data_valid for reads) ends it.
module axi_lite_cmd_arbiter
  import axi_lite_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                        axi_clk,
  input  logic                        sys_areset,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0]            req_write,
  input  logic [N_REQ*AW-1:0]         req_addr,
  input  logic [N_REQ*DW-1:0]         req_wdata,
  input  logic [N_REQ*3-1:0]          req_prot,
  input  logic [N_REQ*(DW/8)-1:0]     req_be,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic [1:0]                  rsp_resp,
  output logic [DW-1:0]               rsp_rdata,
  output logic                        busy,
  output logic [$clog2(N_REQ)-1:0]    grant_id,
  output logic                        ctrl_start_write,
  output logic                        ctrl_start_read,
  output logic [AW-1:0]               ctrl_address,
  output logic [DW-1:0]               ctrl_write_data,
  output logic [2:0]                  ctrl_prot,
  output logic [DW/8-1:0]             ctrl_be,
  input  logic [1:0]                  ctrl_resp,
  input  logic [DW-1:0]               ctrl_read_data,
  input  logic                        ctrl_read_data_valid,
  input  logic                        ctrl_done_write,
  output logic [1:0]                  state_dbg
);

  localparam int IW = $clog2(N_REQ);
  localparam int BW = DW / 8;

  arb_state_t    state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] last_q,  last_d;
  logic          wr_q,    wr_d;
  logic [AW-1:0] addr_q,  addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [2:0]    prot_q,  prot_d;
  logic [BW-1:0] be_q,    be_d;
  logic [1:0]    resp_q,  resp_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic [IW-1:0] pick;
  logic          pick_any;
  logic          cmpl;

  rr_priority_pick #(.N_REQ(N_REQ)) u_pick (
    .req        (req_valid),
    .last_grant (last_q),
    .grant      (pick),
    .any        (pick_any)
  );

  // Only the strobe matching the latched op ends WAIT; the other is ignored.
  assign cmpl = wr_q ? ctrl_done_write : ctrl_read_data_valid;

  // State register (FSM plus command/response registers).
  always_ff @(posedge axi_clk or posedge sys_areset) begin
    if (sys_areset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(N_REQ - 1);   // requester 0 wins first after reset
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      prot_q  <= '0;
      be_q    <= '0;
      resp_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      prot_q  <= prot_d;
      be_q    <= be_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    prot_d  = prot_q;
    be_d    = be_q;
    resp_d  = resp_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick;
          wr_d    = req_write[pick];
          addr_d  = req_addr[pick*AW +: AW];
          wdata_d = req_wdata[pick*DW +: DW];
          prot_d  = req_prot[pick*3 +: 3];
          be_d    = req_be[pick*BW +: BW];
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (cmpl) begin
          resp_d = ctrl_resp;
          if (!wr_q) rdata_d = ctrl_read_data;
          last_d  = grant_q;
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    busy             = (state_q != IDLE);
    ctrl_start_write = (state_q == ISSUE) &&  wr_q;
    ctrl_start_read  = (state_q == ISSUE) && !wr_q;
    rsp_valid        = '0;
    if (state_q == RESP) rsp_valid[grant_q] = 1'b1;
  end

  assign grant_id        = grant_q;
  assign ctrl_address    = addr_q;
  assign ctrl_write_data = wdata_q;
  assign ctrl_prot       = prot_q;
  assign ctrl_be         = be_q;
  assign rsp_resp        = resp_q;
  assign rsp_rdata       = rdata_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_axi_lite_cmd_arbiter.sv
// Bench for axi_lite_cmd_arbiter: directed transactions, a controller model,
// and two expected queues (start commands and responses) drained by monitors.
module tb_axi_lite_cmd_arbiter;
  import axi_lite_arb_pkg::*;

  localparam int N_REQ = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int BW    = 4;
  localparam int IW    = 2;
  localparam int RW    = 4 + 2 + DW + IW;              // response entry
  localparam int SW    = 2 + AW + DW + 3 + BW + IW;    // start entry

  // clock / reset
  logic axi_clk;
  logic sys_areset;
  int   cyc = 0;

  initial begin
    axi_clk = 1'b0;
    forever #5 axi_clk = ~axi_clk;
  end
  always @(posedge axi_clk) cyc <= cyc + 1;

  // DUT signals
  logic [N_REQ-1:0]    req_valid, req_write;
  logic [N_REQ*AW-1:0] req_addr;
  logic [N_REQ*DW-1:0] req_wdata;
  logic [N_REQ*3-1:0]  req_prot;
  logic [N_REQ*BW-1:0] req_be;
  logic [N_REQ-1:0]    rsp_valid;
  logic [1:0]          rsp_resp;
  logic [DW-1:0]       rsp_rdata;
  logic                busy;
  logic [IW-1:0]       grant_id;
  logic                ctrl_start_write, ctrl_start_read;
  logic [AW-1:0]       ctrl_address;
  logic [DW-1:0]       ctrl_write_data;
  logic [2:0]          ctrl_prot;
  logic [BW-1:0]       ctrl_be;
  logic [1:0]          ctrl_resp;
  logic [DW-1:0]       ctrl_read_data;
  logic                ctrl_read_data_valid, ctrl_done_write;
  logic [1:0]          state_dbg;

  axi_lite_cmd_arbiter #(.N_REQ(N_REQ), .AW(AW), .DW(DW)) dut (
    .axi_clk              (axi_clk),
    .sys_areset           (sys_areset),
    .req_valid            (req_valid),
    .req_write            (req_write),
    .req_addr             (req_addr),
    .req_wdata            (req_wdata),
    .req_prot             (req_prot),
    .req_be               (req_be),
    .rsp_valid            (rsp_valid),
    .rsp_resp             (rsp_resp),
    .rsp_rdata            (rsp_rdata),
    .busy                 (busy),
    .grant_id             (grant_id),
    .ctrl_start_write     (ctrl_start_write),
    .ctrl_start_read      (ctrl_start_read),
    .ctrl_address         (ctrl_address),
    .ctrl_write_data      (ctrl_write_data),
    .ctrl_prot            (ctrl_prot),
    .ctrl_be              (ctrl_be),
    .ctrl_resp            (ctrl_resp),
    .ctrl_read_data       (ctrl_read_data),
    .ctrl_read_data_valid (ctrl_read_data_valid),
    .ctrl_done_write      (ctrl_done_write),
    .state_dbg            (state_dbg)
  );

  logic [113:0] outs;
  assign outs = {rsp_valid, rsp_resp, rsp_rdata, busy, grant_id, ctrl_start_write,
                 ctrl_start_read, ctrl_address, ctrl_write_data, ctrl_prot, ctrl_be};

  // scoreboard state
  logic [RW-1:0] exp_q[$];
  logic [SW-1:0] start_q[$];
  int n_vec = 0;
  int n_err = 0;
  int remain[N_REQ];

  // controller model knobs
  int         model_lat;
  logic [1:0] model_resp;
  logic [31:0] model_rdata;
  logic       model_stray;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic set_req(input int i, input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] p, input logic [3:0] b);
    req_write[i]          = wr;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
    req_prot[i*3 +: 3]    = p;
    req_be[i*BW +: BW]    = b;
  endtask

  task automatic expect_txn(input int i, input logic wr, input logic [31:0] a, input logic [31:0] d,
                            input logic [2:0] p, input logic [3:0] b,
                            input logic [1:0] resp, input logic [31:0] rdata);
    logic [3:0] oh;
    oh = 4'b0001 << i;
    start_q.push_back({wr, !wr, a, d, p, b, 2'(i)});
    exp_q.push_back({oh, resp, rdata, 2'(i)});
  endtask

  // Holds requests until each requester has seen remain[i] responses,
  // dropping req_valid on the edge ending its last rsp_valid cycle.
  task automatic serve(input int n);
    int seen;
    int guard;
    logic [N_REQ-1:0] drop;
    seen = 0; guard = 0; drop = '0;
    while (seen < n && guard < 200) begin
      @(posedge axi_clk); #1;
      guard++;
      req_valid = req_valid & ~drop;
      drop = '0;
      for (int i = 0; i < N_REQ; i++) begin
        if (rsp_valid[i]) begin
          seen++;
          remain[i]--;
          if (remain[i] <= 0) drop[i] = 1'b1;
        end
      end
    end
    @(posedge axi_clk); #1;
    req_valid = req_valid & ~drop;
    check("serve_responses_seen", 128'(seen), 128'(n));
  endtask

  // controller model
  initial begin
    logic is_wr;
    logic abort;
    ctrl_resp = '0; ctrl_read_data = '0; ctrl_read_data_valid = 1'b0; ctrl_done_write = 1'b0;
    forever begin
      @(posedge axi_clk); #1;
      if (!sys_areset && (ctrl_start_write || ctrl_start_read)) begin
        is_wr = ctrl_start_write;
        abort = 1'b0;
        @(posedge axi_clk); #1;                   // first WAIT cycle
        if (model_stray && !is_wr) begin
          ctrl_resp = 2'b11; ctrl_done_write = 1'b1;
          @(posedge axi_clk); #1;
          ctrl_done_write = 1'b0; ctrl_resp = '0;
        end
        for (int i = 0; i < model_lat; i++) begin
          if (sys_areset) abort = 1'b1;
          if (!abort) begin @(posedge axi_clk); #1; end
        end
        if (sys_areset) abort = 1'b1;
        if (!abort) begin
          ctrl_resp = model_resp;
          if (is_wr) begin
            ctrl_done_write = 1'b1;
            ctrl_read_data  = $urandom();
          end else begin
            ctrl_read_data       = model_rdata;
            ctrl_read_data_valid = 1'b1;
          end
          @(posedge axi_clk); #1;
          ctrl_done_write = 1'b0; ctrl_read_data_valid = 1'b0;
          ctrl_resp = '0; ctrl_read_data = $urandom();
        end
      end
    end
  end

  // response monitor
  initial begin
    forever begin
      @(posedge axi_clk); #1;
      if (rsp_valid != '0) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL rsp_unexpected: got rsp_valid=%b grant_id=%0d expected no response", rsp_valid, grant_id);
        end else begin
          check("rsp", {rsp_valid, rsp_resp, rsp_rdata, grant_id}, exp_q.pop_front());
        end
      end
    end
  end

  // start monitor: command fields at each start pulse, plus pulse spacing
  initial begin
    int last_start;
    last_start = -1;
    forever begin
      @(posedge axi_clk); #1;
      if (sys_areset) last_start = -1;
      if (ctrl_start_write || ctrl_start_read) begin
        if (last_start >= 0) begin
          n_vec++;
          if (cyc - last_start < 4) begin
            n_err++;
            $display("FAIL start_spacing: got %0d cycles required >= 4", cyc - last_start);
          end
        end
        last_start = cyc;
        if (start_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL start_unexpected: got start w=%b r=%b addr=%h expected none",
                   ctrl_start_write, ctrl_start_read, ctrl_address);
        end else begin
          check("start_cmd", {ctrl_start_write, ctrl_start_read, ctrl_address, ctrl_write_data,
                              ctrl_prot, ctrl_be, grant_id}, start_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // stimulus
  logic [31:0] a_tab[N_REQ] = '{32'h0000_A000, 32'h0000_A010, 32'h0000_A020, 32'h0000_A030};
  logic [31:0] d_tab[N_REQ] = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003};
  logic [3:0]  b_tab[N_REQ] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  initial begin
    sys_areset = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_prot = '0; req_be = '0;
    model_lat = 1; model_resp = RESP_OKAY; model_rdata = '0; model_stray = 1'b0;
    for (int i = 0; i < N_REQ; i++) remain[i] = 0;

    #12;
    check("reset_outputs", 128'(outs), 128'(0));
    check("reset_busy", 128'(busy), 128'(0));
    check("reset_state", 128'(state_dbg), 128'(IDLE));
    #10 sys_areset = 1'b0;
    @(posedge axi_clk); #1;

    // All four write together and keep requesting: grants 0,1,2,3,0,1,2,3.
    for (int i = 0; i < N_REQ; i++) set_req(i, 1'b1, a_tab[i], d_tab[i], 3'(i), b_tab[i]);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N_REQ; i++)
        expect_txn(i, 1'b1, a_tab[i], d_tab[i], 3'(i), b_tab[i], RESP_OKAY, 32'h0);
    for (int i = 0; i < N_REQ; i++) remain[i] = 2;
    req_valid = 4'hF;
    serve(8);

    // Single read by requester 2.
    model_lat = 2; model_rdata = 32'hDEAD_BEEF;
    set_req(2, 1'b0, 32'h0000_1000, 32'h0, 3'b000, 4'hF);
    expect_txn(2, 1'b0, 32'h0000_1000, 32'h0, 3'b000, 4'hF, RESP_OKAY, 32'hDEAD_BEEF);
    remain[2] = 1; req_valid[2] = 1'b1;
    serve(1);

    // Write with SLVERR: resp forwarded, rdata keeps DEADBEEF.
    model_lat = 1; model_resp = RESP_SLVERR;
    set_req(1, 1'b1, 32'h0000_2004, 32'hCAFE_F00D, 3'b010, 4'b0011);
    expect_txn(1, 1'b1, 32'h0000_2004, 32'hCAFE_F00D, 3'b010, 4'b0011, RESP_SLVERR, 32'hDEAD_BEEF);
    remain[1] = 1; req_valid[1] = 1'b1;
    serve(1);

    // Read with a stray done_write in WAIT.
    model_resp = RESP_OKAY; model_stray = 1'b1; model_lat = 2; model_rdata = 32'h1234_5678;
    set_req(3, 1'b0, 32'h0000_3008, 32'h0, 3'b001, 4'hF);
    expect_txn(3, 1'b0, 32'h0000_3008, 32'h0, 3'b001, 4'hF, RESP_OKAY, 32'h1234_5678);
    remain[3] = 1; req_valid[3] = 1'b1;
    serve(1);
    model_stray = 1'b0;

    // Completion in first WAIT cycle, back-to-back (spacing exactly 4).
    model_lat = 0; model_rdata = 32'h0BAD_CAFE;
    set_req(0, 1'b0, 32'h0000_0040, 32'h0, 3'b000, 4'hF);
    set_req(1, 1'b1, 32'h0000_0044, 32'h5555_AAAA, 3'b100, 4'b1100);
    expect_txn(0, 1'b0, 32'h0000_0040, 32'h0, 3'b000, 4'hF, RESP_OKAY, 32'h0BAD_CAFE);
    expect_txn(1, 1'b1, 32'h0000_0044, 32'h5555_AAAA, 3'b100, 4'b1100, RESP_OKAY, 32'h0BAD_CAFE);
    remain[0] = 1; remain[1] = 1; req_valid = 4'b0011;
    serve(2);

    // Reset in WAIT: outputs drop at once, no response, requester 0 first after.
    model_lat = 40;
    set_req(2, 1'b0, 32'h0000_5000, 32'h0, 3'b000, 4'hF);
    start_q.push_back({1'b0, 1'b1, 32'h0000_5000, 32'h0, 3'b000, 4'hF, 2'd2});
    req_valid = 4'b0100;
    begin
      int g;
      g = 0;
      while (!ctrl_start_read && g < 20) begin @(posedge axi_clk); #1; g++; end
      check("abort_start_seen", 128'(ctrl_start_read), 128'(1));
    end
    @(posedge axi_clk);
    @(posedge axi_clk);
    #3 sys_areset = 1'b1;
    #1;
    check("abort_outputs", 128'(outs), 128'(0));
    check("abort_state", 128'(state_dbg), 128'(IDLE));
    req_valid = '0;
    @(posedge axi_clk);
    @(posedge axi_clk);
    #4 sys_areset = 1'b0;

    model_lat = 1; model_rdata = 32'h600D_0001;
    set_req(0, 1'b0, 32'h0000_6000, 32'h0, 3'b011, 4'hF);
    set_req(2, 1'b1, 32'h0000_6100, 32'h7777_8888, 3'b000, 4'b1111);
    expect_txn(0, 1'b0, 32'h0000_6000, 32'h0, 3'b011, 4'hF, RESP_OKAY, 32'h600D_0001);
    expect_txn(2, 1'b1, 32'h0000_6100, 32'h7777_8888, 3'b000, 4'b1111, RESP_OKAY, 32'h600D_0001);
    remain[0] = 1; remain[2] = 1; req_valid = 4'b0101;
    serve(2);

    repeat (4) @(posedge axi_clk);
    #1;
    check("exp_q_drained", 128'(exp_q.size()), 128'(0));
    check("start_q_drained", 128'(start_q.size()), 128'(0));
    check("idle_at_end", 128'(busy), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axi_lite_cmd_arbiter.md
# axi_lite_cmd_arbiter

Round-robin arbiter that shares one `axi_lite_ctrl` command port between `N_REQ` independent requesters. It sits between several bus-side agents and the single AXI-Lite controller. It serialises their read/write commands, holds each command stable until the controller completes it, and routes response and read data back to the requester that issued it. Exactly one transaction is outstanding at any time.

## Interface
- `N_REQ`, 4, number of requesters (2..16)
- `AW`, 32, command address width (matches controller `AW_APB`)
- `DW`, 32, command data width (matches controller `DW_APB`; multiple of 8)

Ports:
- `axi_clk` in 1 — sole clock, all logic rising-edge
- `sys_areset` in 1 — asynchronous, active-high reset
- `req_valid` in N_REQ — per-requester command request, level, held until its `rsp_valid`
- `req_write` in N_REQ — 1 = write, 0 = read
- `req_addr` in N_REQ*AW — packed addresses, requester i at [i*AW +: AW]
- `req_wdata` in N_REQ*DW — packed write data
- `req_prot` in N_REQ*3 — packed AXI prot
- `req_be` in N_REQ*DW/8 — packed byte enables
- `rsp_valid` out N_REQ — one-hot, one-cycle completion pulse
- `rsp_resp` out 2 — response of completed transaction
- `rsp_rdata` out DW — read data, valid with `rsp_valid` for reads
- `busy` out 1 — high whenever state ≠ IDLE
- `grant_id` out $clog2(N_REQ) — index of current/last granted requester
- `ctrl_start_write` / `ctrl_start_read` out 1 — one-cycle start pulses to controller
- `ctrl_address` out AW, `ctrl_write_data` out DW, `ctrl_prot` out 3, `ctrl_be` out DW/8 — registered command fields
- `ctrl_resp` in 2, `ctrl_read_data` in DW, `ctrl_read_data_valid` in 1, `ctrl_done_write` in 1 — controller completion

## Operation
- Reset values: every output 0. Internal `last_grant` is N_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If `|req_valid`, select the first set bit searching upward from `last_grant+1`, wrapping modulo N_REQ.
  - Latch `grant_id`, op, and all command fields into `ctrl_*` registers.
  - Go to ISSUE.
- ISSUE:
  - Pulse `ctrl_start_write` or `ctrl_start_read` for exactly one cycle, per the latched op.
  - Go to WAIT.
- WAIT:
  - Write: leave only on `ctrl_done_write`. Read: leave only on `ctrl_read_data_valid`.
  - A completion strobe for the other op type is ignored.
  - On completion, register `rsp_resp <= ctrl_resp`. For reads, also register `rsp_rdata <= ctrl_read_data`.
  - Set `rsp_valid[grant_id]`, update `last_grant <= grant_id`, and go to RESP.
- RESP:
  - `rsp_valid` is high for this cycle only.
  - Go to IDLE. Re-arbitration happens there on the following cycle.
- `ctrl_*` command fields stay stable from IDLE exit until the next grant, so the controller may sample them any time after the pulse.
- `rsp_rdata` holds its last value across writes. `rsp_resp` holds until the next completion.
- Error responses (`ctrl_resp ≠ 0`) are forwarded unchanged. The arbiter does not retry.
- Requester rule: drop or change `req_valid` only on the edge that ends its `rsp_valid` cycle.
  - Withdrawing `req_valid` after grant does not abort the transaction; the response is still delivered.
  - Changing `req_*` fields after grant has no effect.

## Timing
- Grant latency: `req_valid` high in IDLE → `ctrl_start_*` pulse 1 cycle later (ISSUE cycle).
- Completion: `ctrl_done_write` / `ctrl_read_data_valid` high in cycle T → `rsp_valid` high in T+1.
- Minimum spacing between successive `ctrl_start_*` pulses is 4 cycles (IDLE, ISSUE, WAIT ≥1, RESP). This covers the controller's requirement that its completion flag be low before a new start.
- Simultaneous requests: round-robin, fair. With all N_REQ requests held, grants go 0,1,…,N_REQ-1,0.
- Completion in the first WAIT cycle is legal.
- `sys_areset` mid-transaction: immediate return to IDLE and all outputs 0. No `rsp_valid` is generated for the lost transaction. The controller must be reset by the same signal.

## Structure
- Shared package `axi_lite_arb_pkg`:
  - `arb_state_t` enum (IDLE, ISSUE, WAIT, RESP)
  - Response constants `RESP_OKAY` = 2'b00, `RESP_SLVERR` = 2'b10
  - Function `rr_next(req, last)` for the round-robin search
- Sub-module `rr_priority_pick`:
  - Purely combinational; inputs `req` and `last_grant`, outputs `grant` index and `any`
  - Reused by future arbiters
- FSM, command mux and response demux live in the top module.
- Top module is instantiated beside `axi_lite_ctrl`, with `ctrl_*` ports wired to it.

## Test plan
- Single read: requester 2 reads 0x0000_1000; controller model returns 0xDEAD_BEEF with resp 0 → exactly one `ctrl_start_read`, then `rsp_valid` = 4'b0100 with `rsp_rdata` = 0xDEAD_BEEF and `rsp_resp` = 0.
- All four requesters write simultaneously and re-request immediately, for 8 transactions → `grant_id` sequence 0,1,2,3,0,1,2,3; `ctrl_address` matches the granted requester each time.
- Write completing with `ctrl_resp` = 2'b10 → `rsp_resp` = 2'b10 to the owner; `rsp_rdata` keeps its previous value.
- Read in WAIT while the model emits a stray `ctrl_done_write` → no response; the later `ctrl_read_data_valid` completes it.
- Completion strobe in the first WAIT cycle → `rsp_valid` in the next cycle; next `ctrl_start_*` no earlier than 4 cycles after the previous one.
- `sys_areset` asserted in WAIT → all outputs 0 asynchronously, no `rsp_valid`; after release, requester 0 is granted first.
